// File: rtl/paint_overlay_if.sv
// rtl/paint_overlay_if.sv - pixel request/response bundle between canvas/driver side and the overlay
interface paint_overlay_if #(
  parameter int WIDTH       = 640,
  parameter int HEIGHT      = 480,
  parameter int COLOR_WIDTH = 3
);
  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);

  logic                   toggle;
  logic [XW-1:0]          cursor_x;
  logic [YW-1:0]          cursor_y;
  logic [XW-1:0]          request_x;
  logic [YW-1:0]          request_y;
  logic                   cursor_visible;
  logic [COLOR_WIDTH-1:0] canvas1_color;
  logic [COLOR_WIDTH-1:0] canvas2_color;
  logic [COLOR_WIDTH-1:0] canvas3_color;
  logic [COLOR_WIDTH-1:0] canvas4_color;
  logic                   canvas1_visible;
  logic                   canvas2_visible;
  logic                   canvas3_visible;
  logic                   canvas4_visible;
  logic [7:0]             camera_r;
  logic [7:0]             camera_g;
  logic [7:0]             camera_b;
  logic [COLOR_WIDTH-1:0] current_color;
  logic [7:0]             render_r;
  logic [7:0]             render_g;
  logic [7:0]             render_b;

  modport master (
    output toggle, cursor_x, cursor_y, request_x, request_y, cursor_visible,
           canvas1_color, canvas2_color, canvas3_color, canvas4_color,
           canvas1_visible, canvas2_visible, canvas3_visible, canvas4_visible,
           camera_r, camera_g, camera_b,
    input  current_color, render_r, render_g, render_b
  );

  modport slave (
    input  toggle, cursor_x, cursor_y, request_x, request_y, cursor_visible,
           canvas1_color, canvas2_color, canvas3_color, canvas4_color,
           canvas1_visible, canvas2_visible, canvas3_visible, canvas4_visible,
           camera_r, camera_g, camera_b,
    output current_color, render_r, render_g, render_b
  );
endinterface

// File: rtl/paint_overlay.sv
// rtl/paint_overlay.sv - brush color selector, registered crosshair hit test and layer compositor
module paint_overlay #(
  parameter int WIDTH         = 640,
  parameter int HEIGHT        = 480,
  parameter int CURSOR_RADIUS = 3,
  parameter int COLOR_WIDTH   = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  paint_overlay_if.slave       bus
);
  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam logic [COLOR_WIDTH-1:0] COLOR_NONE  = '0;
  localparam logic [COLOR_WIDTH-1:0] COLOR_FIRST = COLOR_WIDTH'(1);
  localparam logic [COLOR_WIDTH-1:0] COLOR_LAST  = COLOR_WIDTH'(7);
  localparam logic [XW+1:0] RADIUS_X = (XW+2)'(CURSOR_RADIUS);
  localparam logic [YW+1:0] RADIUS_Y = (YW+2)'(CURSOR_RADIUS);

  logic                   prev_toggle;
  logic [COLOR_WIDTH-1:0] current_color;
  logic [COLOR_WIDTH-1:0] cursor_color;

  logic signed [XW+1:0] dx;
  logic signed [YW+1:0] dy;
  logic [XW+1:0]        abs_dx;
  logic [YW+1:0]        abs_dy;
  logic                 hit;

  // Two guard bits keep the differences signed and non-wrapping, so arms clip at screen edges.
  always_comb begin
    dx     = $signed({2'b00, bus.request_x}) - $signed({2'b00, bus.cursor_x});
    dy     = $signed({2'b00, bus.request_y}) - $signed({2'b00, bus.cursor_y});
    abs_dx = (dx < 0) ? -dx : dx;
    abs_dy = (dy < 0) ? -dy : dy;
    hit    = ((dx == 0) && (abs_dy <= RADIUS_Y)) ||
             ((dy == 0) && (abs_dx <= RADIUS_X));
  end

  // prev_toggle tracks the button even in reset so a held button does not advance afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_toggle   <= bus.toggle;
      current_color <= COLOR_FIRST;
      cursor_color  <= COLOR_NONE;
    end else begin
      prev_toggle  <= bus.toggle;
      cursor_color <= hit ? current_color : COLOR_NONE;
      if (bus.toggle && !prev_toggle)
        current_color <= (current_color == COLOR_LAST) ? COLOR_FIRST : current_color + COLOR_FIRST;
    end
  end

  function automatic logic [23:0] palette(input logic [COLOR_WIDTH-1:0] idx);
    case (idx)
      COLOR_WIDTH'(1): return 24'h000000;
      COLOR_WIDTH'(2): return 24'hFFFFFF;
      COLOR_WIDTH'(3): return 24'hFF0000;
      COLOR_WIDTH'(4): return 24'h00FF00;
      COLOR_WIDTH'(5): return 24'h0000FF;
      COLOR_WIDTH'(6): return 24'hFFFF00;
      COLOR_WIDTH'(7): return 24'h00FFFF;
      default:         return 24'h000000;
    endcase
  endfunction

  logic [COLOR_WIDTH-1:0] sel;
  logic                   use_camera;
  logic [23:0]            rgb;

  always_comb begin
    sel        = COLOR_NONE;
    use_camera = 1'b0;
    if (bus.cursor_visible && cursor_color != COLOR_NONE)
      sel = cursor_color;
    else if (bus.canvas4_visible && bus.canvas4_color != COLOR_NONE)
      sel = bus.canvas4_color;
    else if (bus.canvas3_visible && bus.canvas3_color != COLOR_NONE)
      sel = bus.canvas3_color;
    else if (bus.canvas2_visible && bus.canvas2_color != COLOR_NONE)
      sel = bus.canvas2_color;
    else if (bus.canvas1_visible && bus.canvas1_color != COLOR_NONE)
      sel = bus.canvas1_color;
    else
      use_camera = 1'b1;
    rgb = use_camera ? {bus.camera_r, bus.camera_g, bus.camera_b} : palette(sel);
  end

  assign bus.current_color = current_color;
  assign bus.render_r      = rgb[23:16];
  assign bus.render_g      = rgb[15:8];
  assign bus.render_b      = rgb[7:0];
endmodule

// File: tb/tb_paint_overlay.sv
// tb/tb_paint_overlay.sv - directed vector bench for paint_overlay
module tb_paint_overlay;
  localparam int W = 640;
  localparam int H = 480;

  logic clk = 1'b0;
  logic reset;
  int   n_vec  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  paint_overlay_if #(.WIDTH(W), .HEIGHT(H), .COLOR_WIDTH(3)) bus ();

  paint_overlay #(.WIDTH(W), .HEIGHT(H), .CURSOR_RADIUS(3), .COLOR_WIDTH(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int        cx, cy, rx, ry;
    bit        cv;
    int        c1, c2, c3, c4;
    bit [3:0]  vis;   // {canvas4, canvas3, canvas2, canvas1}
    bit [23:0] exp;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  task automatic check_rgb(input string name, input logic [23:0] exp);
    logic [23:0] act;
    act = {bus.render_r, bus.render_g, bus.render_b};
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: render got %06h expected %06h", name, act, exp);
    end
  endtask

  task automatic check_color(input string name, input logic [2:0] exp);
    n_vec++;
    if (bus.current_color !== exp) begin
      n_fail++;
      $display("FAIL %s: current_color got %0d expected %0d", name, bus.current_color, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    bus.toggle = 1'b1;
    tick();
    bus.toggle = 1'b0;
    tick();
  endtask

  task automatic set_req(input int cx, input int cy, input int rx, input int ry);
    bus.cursor_x  = 10'(cx);
    bus.cursor_y  = 9'(cy);
    bus.request_x = 10'(rx);
    bus.request_y = 9'(ry);
  endtask

  initial begin
    // cursor (10,10), brush red, camera 00/AA/AA unless noted
    vecs[0]  = '{10, 10, 10, 13, 1'b1, 0, 0, 0, 0, 4'b0000, 24'hFF0000};
    vecs[1]  = '{10, 10, 10, 14, 1'b1, 0, 0, 0, 0, 4'b0000, 24'h00AAAA};
    vecs[2]  = '{10, 10, 11, 11, 1'b1, 0, 0, 0, 0, 4'b0000, 24'h00AAAA};
    vecs[3]  = '{10, 10, 13, 10, 1'b1, 0, 0, 0, 0, 4'b0000, 24'hFF0000};
    vecs[4]  = '{10, 10,  7, 10, 1'b1, 0, 0, 0, 0, 4'b0000, 24'hFF0000};
    vecs[5]  = '{10, 10, 10,  7, 1'b1, 0, 0, 0, 0, 4'b0000, 24'hFF0000};
    vecs[6]  = '{ 0,  0, W-1, 0, 1'b1, 0, 0, 0, 0, 4'b0000, 24'h00AAAA};
    vecs[7]  = '{ 0,  0,  0,  3, 1'b1, 0, 0, 0, 0, 4'b0000, 24'hFF0000};
    vecs[8]  = '{ 0,  0,  3,  0, 1'b1, 0, 0, 0, 0, 4'b0000, 24'hFF0000};
    vecs[9]  = '{ 5,  0,  5, H-1, 1'b1, 0, 0, 0, 0, 4'b0000, 24'h00AAAA};
    vecs[10] = '{W-1, H-1, W-4, H-1, 1'b1, 0, 0, 0, 0, 4'b0000, 24'hFF0000};
    vecs[11] = '{100, 100, 0, 0, 1'b1, 2, 5, 0, 0, 4'b0011, 24'h0000FF};
    vecs[12] = '{100, 100, 0, 0, 1'b1, 2, 5, 0, 0, 4'b0001, 24'hFFFFFF};
    vecs[13] = '{100, 100, 0, 0, 1'b1, 0, 0, 0, 0, 4'b0011, 24'h00AAAA};
    vecs[14] = '{10, 10, 10, 10, 1'b1, 0, 0, 0, 6, 4'b1000, 24'hFF0000};
    vecs[15] = '{10, 10, 10, 10, 1'b0, 0, 0, 0, 6, 4'b1000, 24'hFFFF00};
    vecs[16] = '{10, 10, 10, 10, 1'b0, 0, 0, 7, 6, 4'b0100, 24'h00FFFF};
    vecs[17] = '{100, 100, 0, 0, 1'b1, 1, 0, 0, 0, 4'b0001, 24'h000000};
    vecs[18] = '{100, 100, 0, 0, 1'b1, 0, 0, 4, 0, 4'b1100, 24'h00FF00};

    reset = 1'b1;
    bus.toggle = 1'b0;
    set_req(100, 100, 0, 0);
    bus.cursor_visible  = 1'b1;
    bus.canvas1_color   = '0; bus.canvas2_color = '0;
    bus.canvas3_color   = '0; bus.canvas4_color = '0;
    bus.canvas1_visible = 1'b0; bus.canvas2_visible = 1'b0;
    bus.canvas3_visible = 1'b0; bus.canvas4_visible = 1'b0;
    bus.camera_r = 8'h00; bus.camera_g = 8'hAA; bus.camera_b = 8'hAA;
    tick();
    tick();
    reset = 1'b0;
    check_color("reset_color", 3'd1);
    check_rgb("reset_render", 24'h00AAAA);

    pulse(); check_color("adv_1", 3'd2);
    pulse(); check_color("adv_2", 3'd3);
    pulse(); check_color("adv_3", 3'd4);

    bus.toggle = 1'b1;
    repeat (10) tick();
    bus.toggle = 1'b0;
    tick();
    check_color("hold_once", 3'd5);

    pulse(); pulse();
    check_color("to_7", 3'd7);
    pulse();
    check_color("wrap", 3'd1);

    pulse(); pulse(); pulse();
    check_color("pre_reset", 3'd4);
    bus.toggle = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (3) tick();
    check_color("held_through_reset", 3'd1);
    bus.toggle = 1'b0;
    repeat (2) tick();
    check_color("after_release", 3'd1);

    pulse(); pulse();
    check_color("brush_red", 3'd3);

    for (int i = 0; i < NV; i++) begin
      set_req(vecs[i].cx, vecs[i].cy, vecs[i].rx, vecs[i].ry);
      bus.cursor_visible  = vecs[i].cv;
      bus.canvas1_color   = 3'(vecs[i].c1);
      bus.canvas2_color   = 3'(vecs[i].c2);
      bus.canvas3_color   = 3'(vecs[i].c3);
      bus.canvas4_color   = 3'(vecs[i].c4);
      bus.canvas1_visible = vecs[i].vis[0];
      bus.canvas2_visible = vecs[i].vis[1];
      bus.canvas3_visible = vecs[i].vis[2];
      bus.canvas4_visible = vecs[i].vis[3];
      tick();
      check_rgb($sformatf("vec_%0d", i), vecs[i].exp);
    end

    bus.canvas1_visible = 1'b0; bus.canvas2_visible = 1'b0;
    bus.canvas3_visible = 1'b0; bus.canvas4_visible = 1'b0;
    bus.cursor_visible  = 1'b1;

    // Hit and color advance sampled at the same edge: old color first, new color next pixel.
    set_req(10, 10, 10, 10);
    bus.toggle = 1'b1;
    tick();
    check_rgb("same_edge_old_color", 24'hFF0000);
    check_color("same_edge_advance", 3'd4);
    tick();
    check_rgb("next_pixel_new_color", 24'h00FF00);
    bus.toggle = 1'b0;
    tick();

    // Reset mid-operation clears the registered cursor color until the next hit edge.
    reset = 1'b1;
    tick();
    check_rgb("reset_mid_render", 24'h00AAAA);
    check_color("reset_mid_color", 3'd1);
    reset = 1'b0;
    tick();
    check_rgb("post_reset_hit", 24'h000000);

    // No hit: registered cursor color goes back to NONE one edge later.
    set_req(10, 10, 200, 200);
    check_rgb("hit_still_registered", 24'h000000);
    tick();
    check_rgb("miss_registered", 24'h00AAAA);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/paint_overlay.md
# paint_overlay

Per-pixel overlay stage of the paint pipeline: selects the active brush color from mouse right-clicks and renders a crosshair cursor for the pixel the VGA driver requests. It composites cursor, four canvas layers and camera background into 24-bit RGB. It sits between the canvas RAMs and the video driver.

## Interface
Parameters:
- WIDTH, 640, screen width; x ports are $clog2(WIDTH) bits (XW).
- HEIGHT, 480, screen height; y ports are $clog2(HEIGHT) bits (YW).
- CURSOR_RADIUS, 3, crosshair arm length in pixels.
- COLOR_WIDTH, 3, palette index width (codebase constant).

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock (CLOCK_50).
- reset  in  1  synchronous, active-high.
- toggle  in  1  right mouse button level; each rising edge advances the color.
- cursor_x  in  XW  cursor column.
- cursor_y  in  YW  cursor row, already inverted to screen orientation.
- request_x  in  XW  pixel column requested by the video driver.
- request_y  in  YW  pixel row requested by the video driver.
- cursor_visible  in  1  cursor layer enable.
- canvasN_color  in  COLOR_WIDTH  canvas N pixel at request (N=1..4), one cycle after request.
- canvasN_visible  in  1  canvas N enable (N=1..4).
- camera_r/g/b  in  8 each  background RGB.
- current_color  out  COLOR_WIDTH  active brush color.
- render_r/g/b  out  8 each  composited pixel.

## Operation
- Palette (index: RGB): 0 COLOR_NONE (transparent, never rendered); 1 black 00/00/00; 2 white FF/FF/FF; 3 red FF/00/00; 4 green 00/FF/00; 5 blue 00/00/FF; 6 yellow FF/FF/00; 7 cyan 00/FF/FF.
- Color selector: register prev_toggle; on toggle & ~prev_toggle, current_color advances 1→2→…→7→1 (wraps, never 0). Held button advances once.
- Cursor renderer: hit when (request_x==cursor_x and |request_y−cursor_y| ≤ CURSOR_RADIUS) or (request_y==cursor_y and |request_x−cursor_x| ≤ CURSOR_RADIUS). Differences computed in widened signed arithmetic; no wrap-around, so arms clip at screen edges. On hit, cursor color = current_color; otherwise COLOR_NONE.
- Compositor priority, top first: cursor (cursor_visible and color≠NONE), then canvas4, canvas3, canvas2, canvas1 (each only if visible and color≠NONE), then camera_r/g/b.
- Winning palette index is mapped to RGB through the palette. An invisible layer is ignored even if its color is non-NONE.

## Timing
- Reset values: current_color=1 (black); cursor color register=COLOR_NONE; prev_toggle loaded with toggle, so a button held through reset causes no advance.
- Color advance is visible on current_color the cycle after the clock edge that samples the toggle rise.
- Cursor hit test is registered: request at edge k gives the cursor color at edge k+1. This aligns with the one-cycle canvas RAM read.
- Compositor is purely combinational from the registered cursor color, canvasN_*, visibles and camera inputs. No additional latency.
- The cursor uses the current_color value registered at the same edge as the hit test. A color change during a frame affects subsequent pixels only.
- Reset asserted mid-operation: the next edge forces the reset values. The render output then shows canvases or camera until the next registered hit.

## Test plan
- Reset, then toggle rises three times with lows in between → current_color goes 1→2→3→4. Holding toggle high 10 cycles → one advance only.
- Advance from 7 → wraps to 1. Toggle held high through reset → after release current_color stays 1.
- cursor (10,10), current_color=3, request (10,13) → next cycle render=FF/00/00. Request (10,14) or (11,11) → camera passthrough (00/AA/AA).
- cursor (0,0), request (WIDTH−1,0) → no hit (no wrap). Request (0,3) → hit. Request (3,0) → hit.
- No cursor hit, canvas1=2 and canvas2=5 both visible → 00/00/FF. canvas2_visible=0 → FF/FF/FF. Both NONE → camera.
- Cursor hit over canvas4=6 visible, cursor_visible=1 → cursor color. cursor_visible=0 → FF/FF/00.
